// File: rtl/ps2_wasd_decoder.sv
// PS/2 set-2 keyboard receiver that turns WASD / arrow-key make and break codes
// into active-low held-key levels. It also exposes each decoded byte and a frame-error pulse.
module ps2_wasd_decoder #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       w,
    output logic       a,
    output logic       s,
    output logic       d,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_CHECK
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    state_t     state_q, state_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [TW-1:0] tocnt_q, tocnt_d;
    logic [9:0] shift_q, shift_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    // Bit order in both held vectors: 0 = W/Up, 1 = A/Left, 2 = S/Down, 3 = D/Right
    logic [3:0] held_letter_q, held_letter_d;
    logic [3:0] held_arrow_q, held_arrow_d;
    logic [7:0] code_q, code_d;
    logic       code_valid_q, code_valid_d;
    logic       frame_err_q, frame_err_d;

    logic [3:0] letter_hit;
    logic [3:0] arrow_hit;
    logic       frame_ok;

    // Synchronizers idle high so that a reset does not fabricate a falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_s;
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;

    always_comb begin
        letter_hit = 4'b0000;
        case (shift_q[7:0])
            8'h1D:   letter_hit = 4'b0001;
            8'h1C:   letter_hit = 4'b0010;
            8'h1B:   letter_hit = 4'b0100;
            8'h23:   letter_hit = 4'b1000;
            default: letter_hit = 4'b0000;
        endcase
    end

    always_comb begin
        arrow_hit = 4'b0000;
        case (shift_q[7:0])
            8'h75:   arrow_hit = 4'b0001;
            8'h6B:   arrow_hit = 4'b0010;
            8'h72:   arrow_hit = 4'b0100;
            8'h74:   arrow_hit = 4'b1000;
            default: arrow_hit = 4'b0000;
        endcase
    end

    // shift_q = {stop, parity, data[7:0]}; odd parity over data and parity bit
    assign frame_ok = shift_q[9] & (^shift_q[8:0]);

    always_comb begin
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        tocnt_d       = tocnt_q;
        shift_d       = shift_q;
        brk_d         = brk_q;
        ext_d         = ext_q;
        held_letter_d = held_letter_q;
        held_arrow_d  = held_arrow_q;
        code_d        = code_q;
        code_valid_d  = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    if (!data_s) begin
                        state_d  = S_RECV;
                        bitcnt_d = 4'd1;
                        tocnt_d  = '0;
                        shift_d  = '0;
                    end else begin
                        frame_err_d = 1'b1;
                        brk_d       = 1'b0;
                        ext_d       = 1'b0;
                    end
                end
            end

            S_RECV: begin
                if (fall) begin
                    shift_d  = {data_s, shift_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    tocnt_d  = '0;
                    if (bitcnt_q == 4'd10) begin
                        state_d = S_CHECK;
                    end
                end else if (tocnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_IDLE;
                    bitcnt_d    = '0;
                    tocnt_d     = '0;
                    frame_err_d = 1'b1;
                    brk_d       = 1'b0;
                    ext_d       = 1'b0;
                end else begin
                    tocnt_d = tocnt_q + TW'(1);
                end
            end

            S_CHECK: begin
                state_d  = S_IDLE;
                bitcnt_d = '0;
                tocnt_d  = '0;
                if (frame_ok) begin
                    code_d       = shift_q[7:0];
                    code_valid_d = 1'b1;
                    if (shift_q[7:0] == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (shift_q[7:0] == 8'hE0) begin
                        ext_d = 1'b1;
                    end else begin
                        if (ext_q) begin
                            held_arrow_d = brk_q ? (held_arrow_q & ~arrow_hit)
                                                 : (held_arrow_q | arrow_hit);
                        end else begin
                            held_letter_d = brk_q ? (held_letter_q & ~letter_hit)
                                                  : (held_letter_q | letter_hit);
                        end
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    brk_d       = 1'b0;
                    ext_d       = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            bitcnt_q      <= '0;
            tocnt_q       <= '0;
            shift_q       <= '0;
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            held_letter_q <= '0;
            held_arrow_q  <= '0;
            code_q        <= '0;
            code_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            tocnt_q       <= tocnt_d;
            shift_q       <= shift_d;
            brk_q         <= brk_d;
            ext_q         <= ext_d;
            held_letter_q <= held_letter_d;
            held_arrow_q  <= held_arrow_d;
            code_q        <= code_d;
            code_valid_q  <= code_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign w          = ~(held_letter_q[0] | held_arrow_q[0]);
    assign a          = ~(held_letter_q[1] | held_arrow_q[1]);
    assign s          = ~(held_letter_q[2] | held_arrow_q[2]);
    assign d          = ~(held_letter_q[3] | held_arrow_q[3]);
    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/ps2_wasd_decoder.md
Name: ps2_wasd_decoder

Overview:
- Upstream input stage for the player controller: receives PS/2 keyboard frames, decodes set-2 make/break codes, and drives held-key levels w, a, s, d.
- w, a, s, d are active-low to match the player controller's inputs; they are driven low while the key is held.
- WASD letters and the arrow keys are aliases, so either key cluster moves PAC-MAN.
- The block also exposes each decoded byte for debug and a frame-error pulse.

Parameters:
- TIMEOUT_CYCLES, 25000: maximum clk cycles allowed between PS/2 falling edges inside one frame before the partial frame is discarded. At 25 MHz this is 1 ms.
- SYNC_STAGES, 2: number of flip-flops in the synchronizer chains for ps2_clk and ps2_data. Minimum is 2.

Ports:
- clk, input, 1: system clock. This is the single clock domain.
- reset, input, 1: synchronous reset, active-high.
- ps2_clk, input, 1: keyboard clock. Asynchronous to clk, idle high.
- ps2_data, input, 1: keyboard data. Asynchronous to clk, idle high.
- w, output, 1: low while W or Up-arrow is held.
- a, output, 1: low while A or Left-arrow is held.
- s, output, 1: low while S or Down-arrow is held.
- d, output, 1: low while D or Right-arrow is held.
- code, output, 8: last accepted data byte.
- code_valid, output, 1: one-cycle pulse when code is updated.
- frame_err, output, 1: one-cycle pulse when a frame is rejected or times out.

Behaviour:
- Reset:
  - Values: w = a = s = d = 1; code = 0; code_valid = 0; frame_err = 0; bit counter, timeout counter, shift register, brk flag and ext flag = 0.
  - Synchronizer flops reset to 1 (idle line).
  - Reset asserted mid-frame discards the partial frame. The first falling edge after reset is treated as bit 0.
- Synchronization:
  - ps2_clk and ps2_data each pass through a SYNC_STAGES flop chain.
  - fall = previous synced clk & ~current synced clk. This is a one-cycle pulse.
  - ps2_data is sampled from its synced value in the cycle fall is high.
- Receiver FSM:
  - IDLE: on fall, if data = 0, go to RECV with bitcnt = 1. If data = 1 (bad start bit), stay in IDLE and pulse frame_err.
  - RECV: on each fall, shift data in LSB-first into 10 bits (8 data, parity, stop) and increment bitcnt.
  - On the fall where bitcnt = 10 (the stop bit), go to CHECK.
  - CHECK lasts one cycle. The frame is accepted if the stop bit = 1 and XOR(data[7:0], parity) = 1 (odd parity); otherwise it is rejected. The FSM then returns to IDLE.
  - Timeout: in RECV, the timeout counter increments every cycle without fall and clears on fall. When it reaches TIMEOUT_CYCLES, go to IDLE, clear the brk and ext flags, and pulse frame_err.
- Reject handling: pulse frame_err, clear the brk and ext flags, leave the held state unchanged.
- Accept handling, applied in CHECK; all outputs are registered and visible in the cycle after CHECK:
  - code updates and code_valid pulses for every accepted byte, including prefixes.
  - Byte 0xF0 sets brk. Byte 0xE0 sets ext. Both flags persist until the next non-prefix byte.
  - Any other byte is looked up, then brk and ext are both cleared:
    - If ext = 0, look up the letter table: 0x1D = W, 0x1C = A, 0x1B = S, 0x23 = D.
    - If ext = 1, look up the arrow table: 0x75 = Up, 0x6B = Left, 0x72 = Down, 0x74 = Right.
    - On a match, the matching held bit is set (brk = 0) or cleared (brk = 1).
    - Unmatched bytes only clear the flags.
  - Letter and arrow held bits are stored separately, eight bits in total.
  - Output equations: w = ~(held_W | held_Up), a = ~(held_A | held_Left), s = ~(held_S | held_Down), d = ~(held_D | held_Right).
- Boundary cases:
  - Typematic repeat make codes re-set an already-set bit, so there is no visible change.
  - Several keys held at once drive several outputs low. Priority is resolved downstream, not in this block.
  - Releasing W while Up is still held keeps w low.
  - A break for a key that is not held has no effect.
  - The sequence E0 followed by 0x1D does not affect w.
- Latency: the cycle after fall on the stop bit is CHECK; w/a/s/d/code/code_valid are visible the cycle after CHECK.

Test Plan:
- Bench setup: SYNC_STAGES = 2, TIMEOUT_CYCLES = 200, PS/2 half-period = 20 clk.
- Assert reset for 3 cycles mid-frame, then release → w = a = s = d = 1, code = 0, and the next complete frame 0x1D is decoded correctly with w = 0.
- Send 0x1D, then F0 1D → w = 0 one cycle after CHECK of the first frame with code_valid pulses = 1; after the break, w = 1 and three code_valid pulses total (0x1D, 0xF0, 0x1D).
- Send 0x1C, then E0 6B, then F0 1C → a stays low after F0 1C because Left is still held; then E0 F0 6B → a = 1.
- Send 0x23 with parity forced even → frame_err pulses once, d = 1, code unchanged; the following good F0 is treated fresh with no stale flags.
- Send 5 bits of a frame, then idle 250 clk → frame_err pulses after 200 idle cycles; a following complete 0x1B frame is decoded → s = 0.
- Send 0x1D, 0x1B, 0x23 held together → w = s = d = 0, a = 1; then send 0x1D three times as repeats → no output change, three code_valid pulses.
